md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the
//  pipelined MIPS datapath. It runs mult/multu/div/divu over a configurable latency and serves
//  mthi/mtlo/mfhi/mflo. It raises busy so the hazard controller stalls dependent MD instructions in D.
// PARAMETERS
//  WIDTH     32  operand and HI/LO width in bits; products are 2*WIDTH bits
//  MULT_LAT  5   busy cycles for mult/multu (>=1)
//  DIV_LAT   10  busy cycles for div/divu (>=1)
// PORTS
//  clk     in   1        clock; all state updates on the rising edge
//  rst     in   1        synchronous reset, active-high
//  start   in   1        E-stage instruction is a valid MD op this cycle
//  md_op   in   3        0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved
//  d1      in   WIDTH    forwarded rs value; dividend / multiplicand / mthi-mtlo data
//  d2      in   WIDTH    forwarded rt value; divisor / multiplier
//  busy    out  1        operation in flight; HI/LO not yet valid
//  hi      out  WIDTH    HI register; mfhi reads it combinationally in E
//  lo      out  WIDTH    LO register; mflo reads it combinationally in E
//  md_use  out  1        start | busy; the hazard controller ORs it with "D instr is MD" to stall
// BEHAVIOUR
//  - Reset: busy=0, hi=0, lo=0, counter=0, state=IDLE. Reset wins over start in the same cycle.
//    Reset during RUN aborts the operation, and HI/LO stay 0.
//  - FSM IDLE/RUN. In IDLE, start with md_op 0..3 latches operands and op, loads cnt=LAT-1,
//    and moves to RUN. busy=1 from the next cycle.
//  - RUN: cnt decrements each cycle. In the cycle cnt==0, HI/LO are written and the FSM returns
//    to IDLE, so busy=0 from the following cycle. busy is high for exactly LAT cycles.
//  - Results are computed from the latched operands only; changes on d1/d2 after the start
//    cycle have no effect.
//  - mult: {hi,lo} = signed d1 * signed d2. multu: unsigned product, 2*WIDTH bits, no truncation.
//  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
//    divu: unsigned quotient and remainder.
//  - Divisor 0: the operation still takes DIV_LAT cycles, then HI/LO keep their old values.
//  - Signed overflow (-2^(W-1) / -1): lo = -2^(W-1), hi = 0 (two's-complement wrap).
//  - mthi/mtlo in IDLE write hi/lo at the clock edge with no busy. mthi and mtlo never assert busy.
//  - start while busy is a protocol error: the controller guarantees it never happens.
//    The unit ignores it, and the in-flight operation completes unchanged.
//  - The completion edge and start are never simultaneous, because busy is still 1 in the
//    completion cycle. A new op may start in the cycle busy first reads 0.
//  - md_op 6/7 with start: no state change.
//  - hi and lo are outputs of registers, with no combinational path from inputs.
// TESTING
//  - rst held 2 cycles then released -> busy=0, hi=0, lo=0.
//  - mult d1=-3 (0xFFFFFFFD), d2=7 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  - multu d1=0xFFFFFFFF, d2=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
//  - div d1=-7, d2=2 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    divu d1=7, d2=0 -> hi/lo unchanged.
//  - div d1=0x80000000, d2=-1 -> lo=0x80000000, hi=0.
//    mthi 0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0.
//  - Start div, drive rst in its 4th busy cycle -> next cycle busy=0, hi=lo=0.
//    A subsequent mult starts normally.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// A result is written to HI/LO in the last of LAT busy cycles; mthi/mtlo write directly in IDLE.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_use
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               busy_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sgn_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH-1:0]   div_b_s;
  logic [WIDTH-1:0]   q_u_s;
  logic [WIDTH-1:0]   r_u_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;
  logic               res_we_s;

  // Result datapath working only from the latched operands.
  always_comb begin
    sgn_s    = ~op_r[0];
    ext_a_s  = {{WIDTH{sgn_s & a_r[WIDTH-1]}}, a_r};
    ext_b_s  = {{WIDTH{sgn_s & b_r[WIDTH-1]}}, b_r};
    prod_s   = ext_a_s * ext_b_s;
    abs_a_s  = (sgn_s && a_r[WIDTH-1]) ? (WIDTH'(0) - a_r) : a_r;
    abs_b_s  = (sgn_s && b_r[WIDTH-1]) ? (WIDTH'(0) - b_r) : b_r;
    // A zero divisor is replaced so the divider never sees it; the result is discarded anyway.
    div_b_s  = (b_r == WIDTH'(0)) ? WIDTH'(1) : abs_b_s;
    q_u_s    = abs_a_s / div_b_s;
    r_u_s    = abs_a_s % div_b_s;
    res_hi_s = prod_s[2*WIDTH-1:WIDTH];
    res_lo_s = prod_s[WIDTH-1:0];
    res_we_s = 1'b1;
    if (op_r[1]) begin
      res_lo_s = (sgn_s && (a_r[WIDTH-1] ^ b_r[WIDTH-1])) ? (WIDTH'(0) - q_u_s) : q_u_s;
      res_hi_s = (sgn_s && a_r[WIDTH-1]) ? (WIDTH'(0) - r_u_s) : r_u_s;
      res_we_s = (b_r != WIDTH'(0));
    end else begin
      res_we_s = 1'b1;
    end
  end

  // Control FSM, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_W'(0);
      op_r    <= 2'd0;
      a_r     <= WIDTH'(0);
      b_r     <= WIDTH'(0);
      busy_r  <= 1'b0;
      hi_r    <= WIDTH'(0);
      lo_r    <= WIDTH'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_r    <= md_op[1:0];
                a_r     <= d1;
                b_r     <= d2;
                cnt_r   <= md_op[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                state_r <= RUN;
                busy_r  <= 1'b1;
              end
              3'd4:    hi_r <= d1;
              3'd5:    lo_r <= d1;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored here; the in-flight op always runs to completion.
          if (cnt_r == CNT_W'(0)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            if (res_we_s) begin
              hi_r <= res_hi_s;
              lo_r <= res_lo_s;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign hi     = hi_r;
  assign lo     = lo_r;
  assign md_use = start | busy_r;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table-driven op vectors plus hand-written
// sequences for mthi/mtlo, reserved ops, start-while-busy and reset mid-operation.
module tb_md_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_use;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] ehi;
    logic [31:0] elo;
    string       name;
  } vec_t;

  vec_t vecs[11];

  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .md_op  (md_op),
    .d1     (d1),
    .d2     (d2),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_use (md_use)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Issue one op, scramble the operand inputs afterwards, and measure busy length.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm);
    int n;
    start = 1'b1; md_op = op; d1 = a; d2 = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; d1 = $urandom; d2 = $urandom;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({nm, " busy_cycles"}, 32'(n), 32'(lat));
    check({nm, " hi"}, hi, ehi);
    check({nm, " lo"}, lo, elo);
  endtask

  initial begin
    int n;
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1; start = 1'b0; md_op = 3'd0; d1 = 32'h0; d2 = 32'h0;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 5,  32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE, "multu_maxx2"};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"};
    vecs[3]  = '{3'd3, 32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "divu_by0"};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf"};
    vecs[5]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, "multu_maxsq"};
    vecs[6]  = '{3'd0, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000, "mult_minsq"};
    vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2"};
    vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF, "divu_max16"};
    vecs[9]  = '{3'd2, 32'h00000064, 32'h00000000, 10, 32'h0000000F, 32'h0FFFFFFF, "div_by0"};
    vecs[10] = '{3'd0, 32'h12345678, 32'hFFFFFFFF, 5,  32'hFFFFFFFF, 32'hEDCBA988, "mult_negone"};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].ehi, vecs[i].elo, vecs[i].name);

    // mthi / mtlo: immediate write, no busy.
    start = 1'b1; md_op = 3'd4; d1 = 32'h00001234; d2 = 32'hDEADBEEF;
    #1 check("mthi md_use", 32'(md_use), 32'd1);
    @(negedge clk); start = 1'b0;
    check("mthi hi", hi, 32'h00001234);
    check("mthi lo_kept", lo, 32'hEDCBA988);
    check("mthi busy", 32'(busy), 32'd0);
    start = 1'b1; md_op = 3'd5; d1 = 32'h0000ABCD;
    @(negedge clk); start = 1'b0;
    check("mtlo lo", lo, 32'h0000ABCD);
    check("mtlo busy", 32'(busy), 32'd0);

    // Reserved op changes nothing.
    start = 1'b1; md_op = 3'd6; d1 = 32'h55555555; d2 = 32'h00000003;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("rsvd busy", 32'(busy), 32'd0);
    check("rsvd hi", hi, 32'h00001234);
    check("rsvd lo", lo, 32'h0000ABCD);

    // start while busy is ignored: the div (100/7) completes unchanged after 10 cycles.
    start = 1'b1; md_op = 3'd2; d1 = 32'd100; d2 = 32'd7;
    @(negedge clk); start = 1'b0;
    n = 1;
    @(negedge clk); n++;
    start = 1'b1; md_op = 3'd0; d1 = 32'd2; d2 = 32'd2;
    #1 check("busy md_use", 32'(md_use), 32'd1);
    @(negedge clk); n++; start = 1'b0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ignored_start busy_cycles", 32'(n - 1), 32'd10);
    check("ignored_start hi", hi, 32'd2);
    check("ignored_start lo", lo, 32'd14);

    // Reset in the 4th busy cycle of a div aborts it and clears HI/LO.
    start = 1'b1; md_op = 3'd2; d1 = 32'd1000; d2 = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    @(negedge clk);
    check("abort stays_idle", 32'(busy), 32'd0);
    run_op(3'd0, 32'd3, 32'd5, 5, 32'h0, 32'd15, "mult_after_abort");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
